seven_seg_mux: RTL and testbench

Time-multiplexing driver that lets two hex digits share one `seven_segment_led` decoder and one segment bus. It sits directly upstream of `seven_segment_led`: it alternately presents nibble `s0` or `s1` on its `s` output, which feeds the decoder's `s` input. It also drives the two active-low anode enables, with optional dead-time blanking between digits to suppress ghosting.

---
 rtl/seven_seg_mux.sv | 116 +++++++++++
 tb/tb_seven_seg_mux.sv | 136 +++++++++++++
 2 files changed

// File: rtl/seven_seg_mux.sv
// Two-digit time-multiplexer feeding one seven_segment_led decoder; registered nibble and active-low anodes.
// Optional dead-time blanking between digits is compiled in with `define SEVEN_SEG_MUX_BLANK_EN.
module seven_seg_mux #(
    parameter int unsigned DIGIT_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] s,
    output logic       an0,
    output logic       an1,
    output logic       frame
);

    localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] DIG_LAST = CW'(DIGIT_CYCLES - 1);
`ifdef SEVEN_SEG_MUX_BLANK_EN
    localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        START,
        DIG0,
`ifdef SEVEN_SEG_MUX_BLANK_EN
        BLANK0,
        BLANK1,
`endif
        DIG1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    r_s;
    logic [3:0]    w_s_nxt;
    logic          r_an0;
    logic          w_an0_nxt;
    logic          r_an1;
    logic          w_an1_nxt;
    logic          r_frame;
    logic          w_frame_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= START;
            r_cnt   <= '0;
            r_s     <= '0;
            r_an0   <= 1'b1;
            r_an1   <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_s     <= w_s_nxt;
            r_an0   <= w_an0_nxt;
            r_an1   <= w_an1_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_s_nxt     = r_s;
        w_an0_nxt   = r_an0;
        w_an1_nxt   = r_an1;
        w_frame_nxt = 1'b0;

        case (r_state)
            START: w_state_nxt = DIG0;
`ifdef SEVEN_SEG_MUX_BLANK_EN
            DIG0:   if (r_cnt == DIG_LAST) w_state_nxt = BLANK0;
            BLANK0: if (r_cnt == BLK_LAST) w_state_nxt = DIG1;
            DIG1:   if (r_cnt == DIG_LAST) w_state_nxt = BLANK1;
            BLANK1: if (r_cnt == BLK_LAST) w_state_nxt = DIG0;
`else
            DIG0:   if (r_cnt == DIG_LAST) w_state_nxt = DIG1;
            DIG1:   if (r_cnt == DIG_LAST) w_state_nxt = DIG0;
`endif
            default: w_state_nxt = START;
        endcase

        // Every exit lands in a different state, so a state change marks an entry edge.
        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
            case (w_state_nxt)
                DIG0: begin
                    w_s_nxt     = s0;
                    w_an0_nxt   = 1'b0;
                    w_an1_nxt   = 1'b1;
                    w_frame_nxt = 1'b1;
                end
                DIG1: begin
                    w_s_nxt   = s1;
                    w_an0_nxt = 1'b1;
                    w_an1_nxt = 1'b0;
                end
                default: begin
                    w_an0_nxt = 1'b1;
                    w_an1_nxt = 1'b1;
                end
            endcase
        end
    end

    assign s     = r_s;
    assign an0   = r_an0;
    assign an1   = r_an1;
    assign frame = r_frame;

endmodule

// File: tb/tb_seven_seg_mux.sv
// Directed bench for seven_seg_mux: a DIGIT_CYCLES=4/BLANK_CYCLES=2 instance and a DIGIT_CYCLES=1 instance.
// Expected outputs come from a per-cycle phase model that follows whichever blanking build is compiled.
module tb_seven_seg_mux;

    localparam int DA = 4;
    localparam int BA = 2;
    localparam int DB = 1;
    localparam int BB = 1;
`ifdef SEVEN_SEG_MUX_BLANK_EN
    localparam int GA = BA;
    localparam int GB = BB;
`else
    localparam int GA = 0;
    localparam int GB = 0;
`endif
    localparam int PA = 2 * (DA + GA);
    localparam int PB = 2 * (DB + GB);

    logic       clk;
    logic       reset;
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] sa;
    logic       an0a, an1a, framea;
    logic [3:0] sb;
    logic       an0b, an1b, frameb;

    int errors = 0;
    int checks = 0;
    int k;
    logic [3:0] cap0a, cap1a, cap0b, cap1b;

    seven_seg_mux #(.DIGIT_CYCLES(DA), .BLANK_CYCLES(BA)) u_dut_a (
        .clk(clk), .reset(reset), .s0(s0), .s1(s1),
        .s(sa), .an0(an0a), .an1(an1a), .frame(framea)
    );

    seven_seg_mux #(.DIGIT_CYCLES(DB), .BLANK_CYCLES(BB)) u_dut_b (
        .clk(clk), .reset(reset), .s0(s0), .s1(s1),
        .s(sb), .an0(an0b), .an1(an1b), .frame(frameb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s k=%0d: got %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // Expected outputs for cycle k of an instance with digit d and gap g cycles.
    task automatic model(input int kk, input int d, input int g, input logic [3:0] c0, input logic [3:0] c1,
                         output logic [3:0] es, output logic ea0, output logic ea1, output logic ef);
        int p;
        p   = kk % (2 * (d + g));
        ef  = (p == 0);
        ea0 = 1'b1;
        ea1 = 1'b1;
        if (p < d) ea0 = 1'b0;
        else if (p >= d + g && p < 2 * d + g) ea1 = 1'b0;
        es  = (p < d + g) ? c0 : c1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_a_s"}, sa, 4'h0);
        chk({tag, "_a_an0"}, {3'b0, an0a}, 4'h1);
        chk({tag, "_a_an1"}, {3'b0, an1a}, 4'h1);
        chk({tag, "_a_frame"}, {3'b0, framea}, 4'h0);
        chk({tag, "_b_s"}, sb, 4'h0);
        chk({tag, "_b_an"}, {2'b0, an0b, an1b}, 4'h3);
    endtask

    task automatic step();
        logic [3:0] es;
        logic       ea0, ea1, ef;
        @(posedge clk);
        k++;
        if (k % PA == 0) cap0a = s0;
        if (k % PA == DA + GA) cap1a = s1;
        if (k % PB == 0) cap0b = s0;
        if (k % PB == DB + GB) cap1b = s1;
        @(negedge clk);
        model(k, DA, GA, cap0a, cap1a, es, ea0, ea1, ef);
        chk("a_s", sa, es);
        chk("a_an0", {3'b0, an0a}, {3'b0, ea0});
        chk("a_an1", {3'b0, an1a}, {3'b0, ea1});
        chk("a_frame", {3'b0, framea}, {3'b0, ef});
        chk("a_anode_overlap", {3'b0, (an0a | an1a)}, 4'h1);
        model(k, DB, GB, cap0b, cap1b, es, ea0, ea1, ef);
        chk("b_s", sb, es);
        chk("b_an", {2'b0, an0b, an1b}, {2'b0, ea0, ea1});
        chk("b_frame", {3'b0, frameb}, {3'b0, ef});
        chk("b_anode_overlap", {3'b0, (an0b | an1b)}, 4'h1);
    endtask

    initial begin
        k     = -1;
        cap0a = '0; cap1a = '0; cap0b = '0; cap1b = '0;
        reset = 1'b1;
        s0    = 4'h3;
        s1    = 4'hA;
        repeat (3) @(negedge clk);
        check_reset_vals("hold");

        reset = 1'b0;
        k     = -1;
        repeat (3 * PA) step();

        // Mid-DIG0 change of s0 must wait for the next DIG0 entry.
        for (int i = 0; i < PA && (k % PA) != 1; i++) step();
        chk("s0_change_phase", 4'(k % PA), 4'h1);
        s0 = 4'h7;
        step();
        chk("s0_hold_old", sa, 4'h3);
        repeat (2 * PA) step();
        chk("s0_new_seen", cap0a, 4'h7);

        // Asynchronous reset in the middle of the gap after digit 0.
        for (int i = 0; i < PA && (k % PA) != DA; i++) step();
        chk("mid_reset_phase", 4'(k % PA), 4'(DA));
        #2 reset = 1'b1;
        #1 check_reset_vals("async");
        @(negedge clk);
        check_reset_vals("async_held");
        reset = 1'b0;
        k     = -1;
        repeat (PA + 2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
